// File: rtl/instr_encoder_pkg.sv
// Shared types and encoding constants for the ARM instruction encoder.
package arm_enc_pkg;

   // Request kind as presented by the host
   typedef enum logic [2:0] {
      KIND_ADD = 3'd0,
      KIND_SUB = 3'd1,
      KIND_AND = 3'd2,
      KIND_ORR = 3'd3,
      KIND_LDR = 3'd4,
      KIND_STR = 3'd5,
      KIND_B   = 3'd6,
      KIND_ILL = 3'd7
   } kind_e;

   // Encoder control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   // Data-processing opcode field
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Instruction class in bits [27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] COND_AL = 4'hE;

   // Assemble a data-processing word: cond | 00 | I | cmd | S | Rn | Rd | src2
   function automatic logic [31:0] dp_word(input logic [3:0]  cond,
                                           input logic        i_bit,
                                           input logic [3:0]  cmd,
                                           input logic        s_bit,
                                           input logic [3:0]  rn,
                                           input logic [3:0]  rd,
                                           input logic [11:0] src2);
      return {cond, OP_DP, i_bit, cmd, s_bit, rn, rd, src2};
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake between the host and the instruction encoder.
interface instr_encoder_if #(parameter int ADDR_W = 6);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [3:0]        in_cond;
   logic              in_s;
   logic              in_imm;
   logic [3:0]        in_rd;
   logic [3:0]        in_rn;
   logic [3:0]        in_rm;
   logic [11:0]       in_imm12;
   logic [ADDR_W-1:0] in_target;
   logic              in_last;

   modport master (
      output in_valid, in_kind, in_cond, in_s, in_imm, in_rd, in_rn, in_rm,
             in_imm12, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_kind, in_cond, in_s, in_imm, in_rd, in_rn, in_rm,
             in_imm12, in_target, in_last,
      output in_ready
   );
endinterface

// File: rtl/arm_instr_pack.sv
// Combinational mapping from request fields and write address to a 32-bit ARM word.
module arm_instr_pack
   import arm_enc_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic [2:0]        kind,
   input  logic [3:0]        cond,
   input  logic              s,
   input  logic              imm,
   input  logic [3:0]        rd,
   input  logic [3:0]        rn,
   input  logic [3:0]        rm,
   input  logic [11:0]       imm12,
   input  logic [ADDR_W-1:0] target,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       word
);

   logic [11:0]       src2;
   logic [ADDR_W+1:0] br_off;
   logic [23:0]       imm24;

   // Build operand fields and select the encoding for the requested kind
   always_comb begin
      src2   = imm ? imm12 : {8'h00, rm};
      // Branch offset is relative to the pipeline PC, two words past this one
      br_off = {2'b00, target} - ({2'b00, wr_addr} + (ADDR_W+2)'(2));
      imm24  = 24'($signed(br_off));
      case (kind_e'(kind))
         KIND_ADD: word = dp_word(cond, imm, CMD_ADD, s, rn, rd, src2);
         KIND_SUB: word = dp_word(cond, imm, CMD_SUB, s, rn, rd, src2);
         KIND_AND: word = dp_word(cond, imm, CMD_AND, s, rn, rd, src2);
         KIND_ORR: word = dp_word(cond, imm, CMD_ORR, s, rn, rd, src2);
         // I=0 P=1 U=1 B=0 W=0, then L
         KIND_LDR: word = {cond, OP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rn, rd, imm12};
         KIND_STR: word = {cond, OP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rn, rd, imm12};
         KIND_B:   word = {cond, OP_BR, 2'b10, imm24};
         default:  word = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction requests and writes encoded words to consecutive memory addresses.
module instr_encoder
   import arm_enc_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   instr_encoder_if.slave    req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   state_e            state_q,     state_d;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
   logic [ADDR_W:0]   count_q,     count_d;
   logic              last_q,      last_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;
   logic [31:0]       enc_word_s;

   arm_instr_pack #(.ADDR_W(ADDR_W)) u_pack (
      .kind    (req.in_kind),
      .cond    (req.in_cond),
      .s       (req.in_s),
      .imm     (req.in_imm),
      .rd      (req.in_rd),
      .rn      (req.in_rn),
      .rm      (req.in_rm),
      .imm12   (req.in_imm12),
      .target  (req.in_target),
      .wr_addr (wr_addr_q),
      .word    (enc_word_s)
   );

   // Ready only while idle; terminal states refuse further requests
   assign req.in_ready = (state_q == ST_IDLE);

   // Next-state and output-register logic of the encoder FSM
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      count_d     = count_q;
      last_d      = last_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      done_d      = done_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req.in_valid) begin
               if (req.in_kind == KIND_ILL) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d     = ST_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_addr_q;
                  mem_wdata_d = enc_word_s;
                  last_d      = req.in_last;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            count_d   = count_q + (ADDR_W+1)'(1);
            // Top address forces completion so the address never wraps
            if (last_q || (wr_addr_q == ADDR_MAX)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_addr_q   <= '0;
         count_q     <= '0;
         last_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0000_0000;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         count_q     <= count_d;
         last_q      <= last_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;
   import arm_enc_pkg::*;

   localparam int ADDR_W = 6;

   logic              clk;
   logic              reset;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              done;
   logic              err;

   int n_cmp;
   int n_mis;
   int writes_seen;
   int exp_count;
   int ws0;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .done      (done),
      .err       (err)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count every cycle in which the memory strobe is high
   always @(posedge clk) begin
      if (mem_we) writes_seen <= writes_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset     = 1'b1;
      exp_count = 0;
   endtask

   task automatic set_fields(input logic [2:0] k, input logic [3:0] c, input logic s,
                             input logic im, input logic [3:0] rd, input logic [3:0] rn,
                             input logic [3:0] rm, input logic [11:0] i12,
                             input logic [ADDR_W-1:0] tgt, input logic lst);
      bus.in_kind   = k;
      bus.in_cond   = c;
      bus.in_s      = s;
      bus.in_imm    = im;
      bus.in_rd     = rd;
      bus.in_rn     = rn;
      bus.in_rm     = rm;
      bus.in_imm12  = i12;
      bus.in_target = tgt;
      bus.in_last   = lst;
   endtask

   // Issue one request, holding in_valid through WRITE, and check the write
   task automatic do_req(input string tag, input logic [2:0] k, input logic [3:0] c,
                         input logic s, input logic im, input logic [3:0] rd,
                         input logic [3:0] rn, input logic [3:0] rm, input logic [11:0] i12,
                         input logic [ADDR_W-1:0] tgt, input logic lst,
                         input logic [ADDR_W-1:0] eaddr, input logic [31:0] edata);
      int n;
      set_fields(k, c, s, im, rd, rn, rm, i12, tgt, lst);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         check_eq({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_we"},    32'(mem_we), 32'd1);
      check_eq({tag, "_addr"},  32'(mem_addr), 32'(eaddr));
      check_eq({tag, "_data"},  mem_wdata, edata);
      check_eq({tag, "_rdy_w"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      exp_count++;
      check_eq({tag, "_we_off"}, 32'(mem_we), 32'd0);
      check_eq({tag, "_count"},  32'(count), 32'(exp_count));
      bus.in_valid = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      writes_seen = 0;
      exp_count   = 0;
      set_fields(3'd0, COND_AL, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 6'd0, 1'b0);
      do_reset();

      // Reset state
      check_eq("rst_we",    32'(mem_we), 32'd0);
      check_eq("rst_addr",  32'(mem_addr), 32'd0);
      check_eq("rst_data",  mem_wdata, 32'h0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_done",  32'(done), 32'd0);
      check_eq("rst_err",   32'(err), 32'd0);
      check_eq("rst_ready", 32'(bus.in_ready), 32'd1);

      // Small program
      ws0 = writes_seen;
      do_req("add",  3'd0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 12'h005, 6'd0, 1'b0, 6'd0, 32'hE282_1005);
      do_req("subs", 3'd1, 4'hE, 1'b1, 1'b0, 4'd3, 4'd4, 4'd5, 12'hABC, 6'd0, 1'b0, 6'd1, 32'hE054_3005);
      do_req("ldr",  3'd4, 4'hE, 1'b0, 1'b0, 4'd6, 4'd7, 4'd0, 12'h008, 6'd0, 1'b0, 6'd2, 32'hE597_6008);
      do_req("str",  3'd5, 4'hE, 1'b0, 1'b0, 4'd6, 4'd7, 4'd0, 12'h008, 6'd0, 1'b0, 6'd3, 32'hE587_6008);
      do_req("beq",  3'd6, 4'h0, 1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 12'hFFF, 6'd0, 1'b0, 6'd4, 32'h0AFF_FFFA);
      do_req("orr",  3'd3, 4'hE, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 12'h001, 6'd0, 1'b1, 6'd5, 32'hE380_0001);
      check_eq("prog_writes", 32'(writes_seen - ws0), 32'd6);
      check_eq("prog_done",   32'(done), 32'd1);
      check_eq("prog_ready",  32'(bus.in_ready), 32'd0);

      // Requests after completion are ignored
      set_fields(3'd0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd1, 4'd1, 12'h001, 6'd0, 1'b0);
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq("post_writes", 32'(writes_seen - ws0), 32'd6);
      check_eq("post_count",  32'(count), 32'd6);
      check_eq("post_done",   32'(done), 32'd1);

      // Illegal kind
      do_reset();
      ws0 = writes_seen;
      set_fields(3'd7, 4'hE, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 12'h001, 6'd0, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("ill_err",   32'(err), 32'd1);
      check_eq("ill_we",    32'(mem_we), 32'd0);
      check_eq("ill_ready", 32'(bus.in_ready), 32'd0);
      check_eq("ill_done",  32'(done), 32'd0);
      bus.in_kind = 3'd0;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq("ill_writes", 32'(writes_seen - ws0), 32'd0);
      check_eq("ill_count",  32'(count), 32'd0);

      // Reset pulled during WRITE drops the write
      do_reset();
      set_fields(3'd0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 12'h005, 6'd0, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rw_we_on", 32'(mem_we), 32'd1);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("rw_we",    32'(mem_we), 32'd0);
      check_eq("rw_addr",  32'(mem_addr), 32'd0);
      check_eq("rw_data",  mem_wdata, 32'h0);
      check_eq("rw_count", 32'(count), 32'd0);
      check_eq("rw_ready", 32'(bus.in_ready), 32'd1);
      reset     = 1'b1;
      exp_count = 0;
      do_req("rw_add", 3'd0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 12'h005, 6'd0, 1'b0, 6'd0, 32'hE282_1005);

      // Fill the whole memory without in_last
      do_reset();
      for (int i = 0; i < 64; i++) begin
         if (i == 10)
            do_req($sformatf("fill%0d", i), 3'd6, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000,
                   6'd20, 1'b0, 6'(i), 32'hEA00_0008);
         else if (i == 63)
            do_req($sformatf("fill%0d", i), 3'd6, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000,
                   6'd0, 1'b0, 6'(i), 32'hEAFF_FFBF);
         else
            do_req($sformatf("fill%0d", i), 3'd0, 4'hE, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 12'(i),
                   6'd0, 1'b0, 6'(i), 32'hE280_0000 | 32'(i));
      end
      check_eq("full_done",  32'(done), 32'd1);
      check_eq("full_ready", 32'(bus.in_ready), 32'd0);
      check_eq("full_count", 32'(count), 32'd64);
      ws0 = writes_seen;
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq("full_writes", 32'(writes_seen - ws0), 32'd0);
      check_eq("full_addr",   32'(mem_addr), 32'd63);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential encoder that turns field-level instruction requests into 32-bit ARM machine words for the subset our decoder executes (ADD, SUB, AND, ORR, LDR, STR, B) and writes them into instruction memory at consecutive word addresses. It sits between the test/boot host and the instruction memory, so programs are produced in exactly the format the decoder consumes. A valid/ready handshake accepts one request. Each word is written one cycle after acceptance. A branch target is converted to a PC-relative offset from the current write address.

## Interface
- ADDR_W, 6: instruction-memory word-address width (≤ 22); memory depth 2^ADDR_W words.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept; transfer when in_valid & in_ready
- in_kind  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDR, 5 STR, 6 B, 7 illegal
- in_cond  in  4  condition field, copied to bits [31:28]
- in_s  in  1  S bit (DP only; forced 0 otherwise)
- in_imm  in  1  DP source2 is immediate (1) or register Rm (0)
- in_rd, in_rn, in_rm  in  4 each  register fields
- in_imm12  in  12  DP immediate (rot:imm8) or LDR/STR offset
- in_target  in  ADDR_W  B target, word address
- in_last  in  1  this request is the final instruction
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since reset
- done  out  1  sticky: program complete or memory full
- err  out  1  sticky: illegal kind received

## Operation
- FSM states: IDLE, WRITE, DONE, ERROR.
  - IDLE: in_ready=1. On transfer with kind≤6, register the encoded word and go to WRITE. On transfer with kind=7, go to ERROR with no write.
  - WRITE: mem_we=1, mem_addr=wr_addr, mem_wdata=registered word. Next cycle: wr_addr+1 and count+1. Go to DONE if the request had in_last or wr_addr==2^ADDR_W−1; otherwise go to IDLE.
  - DONE / ERROR: terminal until reset. in_ready=0 and in_valid is ignored. done=1 in DONE; err=1 in ERROR.
- DP encoding: cond | 00 | I=in_imm | cmd | S | Rn | Rd | src2.
  - cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100.
  - src2 = in_imm12 if in_imm, else {8'b0, Rm} (no shift).
- LDR/STR encoding: cond | 01 | I=0 | P=1 | U=1 | B=0 | W=0 | L | Rn | Rd | in_imm12. L=1 for LDR, 0 for STR.
- B encoding: cond | 10 | 10 | imm24.
  - imm24 = sign-extend to 24 bits of (in_target − (wr_addr+2)), computed in ADDR_W+2-bit signed arithmetic.
- Rd=15 is encoded unchanged; no checking is done.
- Unused input fields are ignored: Rm for an immediate DP, Rn/Rd/imm12 for B.

## Timing
- Reset (reset=0 at an edge) sets: state IDLE, wr_addr 0, count 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0.
  - in_ready is combinational from state, so it is 1 in the first cycle after reset.
  - Reset asserted while in WRITE drops that write: mem_we is 0 in the following cycle and wr_addr stays 0.
- Latency: acceptance at edge N gives mem_we high for cycle N..N+1. Throughput is one word per 2 cycles.
- in_ready=0 in WRITE. Requests presented during WRITE wait (the host holds in_valid and fields stable).
- Wrap-around: no wrap. A write to address 2^ADDR_W−1 forces DONE even without in_last.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Structure
- Package arm_enc_pkg holds:
  - kind enum, DP cmd constants, op constants (DP 00, MEM 01, BR 10), COND_AL=4'hE, state enum.
- One combinational sub-module, arm_instr_pack, maps kind/fields/wr_addr to the 32-bit word.
- The top module holds the FSM, wr_addr, count and the output registers.

## Test plan
- ADD R1,R2,#5 (kind 0, cond E, in_imm 1, S 0, Rn 2, Rd 1, imm12 0x005) after reset → mem_we in the cycle after accept, addr 0, data 0xE2821005, count 1.
- SUBS R3,R4,R5 (kind 1, S 1, in_imm 0, Rm 5) at addr 1 → 0xE0543005. in_valid held high through WRITE must be accepted only once.
- LDR R6,[R7,#8] then STR R6,[R7,#8] → addr 2 gets 0xE5976008, addr 3 gets 0xE5876008.
- B to target 0, cond EQ (0), issued at addr 4 → imm24 = −6 → 0x0AFFFFFA.
- ORR R0,R0,#1 with in_last at addr 5 → 0xE3800001, then done=1, in_ready=0, count=6. Further in_valid produces no write.
- kind 7 → err=1, no mem_we, in_ready=0.
  - Separately, pull reset low in WRITE → no write occurs, and all outputs return to reset values.
- Fill to address 63 without in_last → done=1 after the 64th write, and mem_addr never wraps to 0.
